// File: rtl/aes_inv_cipher_seq.sv
// Iterative AES inverse cipher: one round per clock, external key store.
// Define AES_INV_CIPHER_SEQ_KEY256_EN to add the key256 port (NR=14).

module aes_inv_sbox (
  input  logic [7:0] d,
  output logic [7:0] q
);
  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] a;
  logic [7:0] sq;
  logic [7:0] acc;

  // inverse affine map, then field inverse as a^254 (0 maps to 0)
  always_comb begin
    a = {d[6:0], d[7]} ^ {d[4:0], d[7:5]}
      ^ {d[1:0], d[7:2]} ^ 8'h05;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    q = acc;
  end
endmodule

module aes_inv_mix_columns (
  input  logic [127:0] d,
  output logic [127:0] q
);
  function automatic logic [7:0] xt(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a  [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];
  logic [7:0] x2, x4, x8;

  always_comb begin
    q  = '0;
    x2 = '0;
    x4 = '0;
    x8 = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = d[8*(4*c+r) +: 8];
        x2    = xt(a[r]);
        x4    = xt(x2);
        x8    = xt(x4);
        m9[r] = x8 ^ a[r];
        mb[r] = x8 ^ x2 ^ a[r];
        md[r] = x8 ^ x4 ^ a[r];
        me[r] = x8 ^ x4 ^ x2;
      end
      for (int r = 0; r < 4; r++) begin
        q[8*(4*c+r) +: 8] = me[r]
          ^ mb[(r+1)%4]
          ^ md[(r+2)%4]
          ^ m9[(r+3)%4];
      end
    end
  end
endmodule

module aes_inv_cipher_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
`ifdef AES_INV_CIPHER_SEQ_KEY256_EN
  input  logic         key256,
`endif
  output logic         busy
);
  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } state_t;

  state_t       state, state_nxt;
  logic [127:0] st, st_nxt;
  logic [3:0]   rnd, rnd_nxt;
  logic [3:0]   nr;
  logic [127:0] sr, sb, ark, imc;

  // the key length is carried by rnd after acceptance
`ifdef AES_INV_CIPHER_SEQ_KEY256_EN
  assign nr = key256 ? 4'd14 : 4'd10;
`else
  assign nr = 4'd10;
`endif

  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[8*(r+4*((c+r)%4)) +: 8] =
          st[8*(r+4*c) +: 8];
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .d(sr[8*g +: 8]),
      .q(sb[8*g +: 8])
    );
  end

  assign ark = sb ^ rk_data;

  aes_inv_mix_columns u_imc (
    .d(ark),
    .q(imc)
  );

  always_comb begin
    state_nxt = state;
    st_nxt    = st;
    rnd_nxt   = rnd;
    rk_idx    = nr;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        rk_idx   = nr;
        if (in_valid) begin
          st_nxt    = in_data ^ rk_data;
          rnd_nxt   = nr - 4'd1;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        rk_idx  = rnd;
        st_nxt  = imc;
        rnd_nxt = rnd - 4'd1;
        if (rnd == 4'd1) state_nxt = FINAL;
      end
      FINAL: begin
        rk_idx    = 4'd0;
        st_nxt    = ark;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      st    <= '0;
      rnd   <= '0;
    end else begin
      state <= state_nxt;
      st    <= st_nxt;
      rnd   <= rnd_nxt;
    end
  end

  assign busy     = (state != IDLE);
  assign out_data = st;
endmodule

// File: tb/tb_aes_inv_cipher_seq.sv
// Bench for aes_inv_cipher_seq: FIPS vectors plus random
// blocks checked against a byte-level AES model.
module tb_aes_inv_cipher_seq;
  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         key256;
  logic         busy;

  logic [127:0] ks [16];
  logic [7:0]   sb [256];
  logic [7:0]   isb [256];
  int           total;
  int           bad;

  assign rk_data = ks[rk_idx];

  aes_inv_cipher_seq dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .rk_idx(rk_idx),
    .rk_data(rk_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
`ifdef AES_INV_CIPHER_SEQ_KEY256_EN
    .key256(key256),
`endif
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(logic [7:0] v, int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] cf(bit inv, int k);
    case (k)
      0:       return inv ? 8'h0e : 8'h02;
      1:       return inv ? 8'h0b : 8'h03;
      2:       return inv ? 8'h0d : 8'h01;
      default: return inv ? 8'h09 : 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] rev(logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = v[8*(15-i) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] sub(logic [127:0] v, bit inv);
    for (int i = 0; i < 16; i++)
      v[8*i +: 8] = inv ? isb[v[8*i +: 8]] : sb[v[8*i +: 8]];
    return v;
  endfunction

  function automatic logic [127:0] shift(logic [127:0] v, bit inv);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (inv) o[8*(r+4*((c+r)%4)) +: 8] = v[8*(r+4*c) +: 8];
        else     o[8*(r+4*c) +: 8] = v[8*(r+4*((c+r)%4)) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix(logic [127:0] v, bit inv);
    logic [127:0] o;
    logic [7:0]   acc;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        acc = '0;
        for (int j = 0; j < 4; j++)
          acc ^= gm(cf(inv, (j - i + 4) % 4), v[8*(4*c+j) +: 8]);
        o[8*(4*c+i) +: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] enc(logic [127:0] p, int nr);
    logic [127:0] s;
    s = p ^ ks[0];
    for (int r = 1; r < nr; r++)
      s = mix(shift(sub(s, 0), 0), 0) ^ ks[r];
    return shift(sub(s, 0), 0) ^ ks[nr];
  endfunction

  function automatic logic [127:0] dec(logic [127:0] c, int nr);
    logic [127:0] s;
    s = c ^ ks[nr];
    for (int r = nr - 1; r >= 1; r--)
      s = mix(sub(shift(s, 1), 1) ^ ks[r], 1);
    return sub(shift(s, 1), 1) ^ ks[0];
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nw;
    nw = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {t[7:0], t[31:8]};
        for (int b = 0; b < 4; b++) t[8*b +: 8] = sb[t[8*b +: 8]];
        t[7:0] = t[7:0] ^ rc;
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        for (int b = 0; b < 4; b++) t[8*b +: 8] = sb[t[8*b +: 8]];
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j < nw / 4; j++)
      ks[j] = {w[4*j+3], w[4*j+2], w[4*j+1], w[4*j]};
  endtask

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // entered at a negedge; returns at the negedge after DONE->IDLE
  task automatic run(input logic [127:0] ct, input logic [127:0] exp,
                     input int nr, input int hold, input bit noisy,
                     input logic [127:0] noise);
    in_valid = 1'b1;
    in_data  = ct;
    key256   = (nr == 14);
    chk("acc_ready", in_ready, 1);
    chk("acc_rk", rk_idx, nr);
    @(posedge clk);
    #1;
    in_valid = noisy;
    in_data  = noise;
    key256   = 1'b0;
    for (int k = 1; k <= nr; k++) begin
      @(negedge clk);
      chk("rk_seq", rk_idx, nr - k);
      chk("early_valid", out_valid, 0);
      chk("busy_ready", in_ready, 0);
    end
    @(negedge clk);
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, exp);
      chk("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_valid", out_valid, 0);
    chk("idle_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  logic [255:0] key;
  logic [127:0] ct1, pt1, pt, ct, other;
  logic [7:0]   inv, s;

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    key256    = 1'b0;
    for (int i = 0; i < 16; i++) ks[i] = '0;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gm(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3)
        ^ rl(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = x[7:0];
    end
    ct1 = rev(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    pt1 = rev(128'h00112233445566778899aabbccddeeff);

    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rk", rk_idx, 10);
    chk("rst_data", out_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    key = '0;
    for (int k = 0; k < 32; k++) key[8*k +: 8] = k[7:0];
    expand(key, 4);
    chk("model_c1", dec(ct1, 10), pt1);
    run(ct1, pt1, 10, 0, 0, '0);
    run(ct1, pt1, 10, 20, 0, '0);

    other = {$urandom, $urandom, $urandom, $urandom};
    run(ct1, pt1, 10, 2, 1, other);
    run(other, dec(other, 10), 10, 0, 0, '0);

    in_valid = 1'b1;
    in_data  = ct1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_ready", in_ready, 1);
    chk("mid_valid", out_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_rk", rk_idx, 10);
    chk("mid_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(ct1, pt1, 10, 0, 0, '0);

    for (int i = 0; i < 16; i++) ks[i] = '0;
    run('0, dec('0, 10), 10, 1, 0, '0);

    for (int n = 0; n < 4; n++) begin
      key = {128'h0, $urandom, $urandom, $urandom, $urandom};
      expand(key, 4);
      pt = {$urandom, $urandom, $urandom, $urandom};
      ct = enc(pt, 10);
      run(ct, pt, 10, $urandom_range(0, 3), 0, '0);
    end

`ifdef AES_INV_CIPHER_SEQ_KEY256_EN
    key = '0;
    for (int k = 0; k < 32; k++) key[8*k +: 8] = k[7:0];
    expand(key, 8);
    run(rev(128'h8ea2b7ca516745bfeafc49904b496089),
        pt1, 14, 0, 0, '0);
    expand(key, 4);
    run(ct1, pt1, 10, 0, 0, '0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
